// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage and data_mem_ctrl.
// The master drives requests; the slave (controller) answers with ready and a response pulse.
interface data_mem_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic              req_byte;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_op, req_byte, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_op, req_byte, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: owns the array and sequences LDR/STR/SWP (word and byte) accesses.
// Optional macro MEM_ALIGN_CHECK_EN adds rsp_abort and rejects misaligned word requests.
module data_mem_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   data_mem_ctrl_if.slave bus,
   output logic           mem_read,
   output logic           mem_write,
`ifdef MEM_ALIGN_CHECK_EN
   output logic           rsp_abort,
`endif
   output logic           busy
);
   localparam int unsigned LANE_W = $clog2(DATA_W / 8);
   localparam int unsigned LANES  = DATA_W / 8;
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned USED_W = LANE_W + IDX_W;

   localparam logic [1:0] OpLdr = 2'b00;
   localparam logic [1:0] OpStr = 2'b01;
   localparam logic [1:0] OpSwp = 2'b10;

   typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

   state_e              state_q, state_d;
   logic [1:0]          op_q;
   logic                byte_q;
   logic [USED_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rlat_q;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                abort_q, abort_d;
   logic                accept;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [IDX_W-1:0]    idx;
   logic [LANE_W-1:0]   lane;
   logic [DATA_W-1:0]   mem_word;

   assign idx      = addr_q[USED_W-1:LANE_W];
   assign lane     = addr_q[LANE_W-1:0];
   assign mem_word = mem_q[idx];

   // Address bits above the array index only wrap the access.
   if (ADDR_W > USED_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:USED_W];
   end

   function automatic logic [DATA_W-1:0] pick(input logic [DATA_W-1:0] w,
                                              input logic is_byte,
                                              input logic [LANE_W-1:0] ln);
      if (is_byte) return {{(DATA_W-8){1'b0}}, w[{ln, 3'b000} +: 8]};
      return w;
   endfunction

   always_comb begin
      state_d     = state_q;
      rsp_rdata_d = rsp_rdata_q;
      abort_d     = abort_q;
      accept      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               accept  = 1'b1;
               abort_d = 1'b0;
               unique case (bus.req_op)
                  OpLdr, OpSwp: state_d = StRd;
                  OpStr:        state_d = StWr;
                  default: begin
                     state_d     = StRsp;
                     rsp_rdata_d = '0;
                  end
               endcase
`ifdef MEM_ALIGN_CHECK_EN
               if (!bus.req_byte && bus.req_op != 2'b11 &&
                   bus.req_addr[LANE_W-1:0] != '0) begin
                  state_d     = StRsp;
                  rsp_rdata_d = '0;
                  abort_d     = 1'b1;
               end
`endif
            end
         end
         StRd: begin
            if (op_q == OpSwp) begin
               state_d = StWr;
            end else begin
               state_d     = StRsp;
               rsp_rdata_d = pick(mem_word, byte_q, lane);
            end
         end
         StWr: begin
            state_d     = StRsp;
            rsp_rdata_d = (op_q == OpSwp) ? pick(rlat_q, byte_q, lane) : '0;
         end
         StRsp:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= '0;
         byte_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rlat_q      <= '0;
         rsp_rdata_q <= '0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_rdata_q <= rsp_rdata_d;
         abort_q     <= abort_d;
         if (accept) begin
            op_q    <= bus.req_op;
            byte_q  <= bus.req_byte;
            addr_q  <= bus.req_addr[USED_W-1:0];
            wdata_q <= bus.req_wdata;
         end
         if (state_q == StRd) rlat_q <= mem_word;
      end
   end

   // Array is not reset; a write only happens from WR, which reset always leaves.
   always_ff @(posedge clk) begin
      if (state_q == StWr) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (!byte_q || lane == LANE_W'(i)) begin
               mem_q[idx][i*8 +: 8] <= byte_q ? wdata_q[7:0] : wdata_q[i*8 +: 8];
            end
         end
      end
   end

   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = (state_q == StRsp);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign mem_read      = (state_q == StRd);
   assign mem_write     = (state_q == StWr);
   assign busy          = (state_q != StIdle);
`ifdef MEM_ALIGN_CHECK_EN
   assign rsp_abort     = abort_q;
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: word/byte/swap access, latency, back-to-back and
// mid-operation reset; alignment abort when MEM_ALIGN_CHECK_EN is defined.
module tb_data_mem_ctrl;
   localparam logic [1:0] LDR = 2'b00;
   localparam logic [1:0] STR = 2'b01;
   localparam logic [1:0] SWP = 2'b10;
   localparam logic [1:0] RSV = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic mem_read, mem_write, busy;
   logic abort_sig;
   int   checks = 0;
   int   failures = 0;

   data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

`ifdef MEM_ALIGN_CHECK_EN
   data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .mem_read(mem_read), .mem_write(mem_write),
      .rsp_abort(abort_sig), .busy(busy));
`else
   data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .mem_read(mem_read), .mem_write(mem_write),
      .busy(busy));
   assign abort_sig = 1'b0;
`endif

   always #5 clk = ~clk;

   // Must be called at a negedge; returns at the negedge of the response cycle.
   task automatic do_req(input logic [1:0] op, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                         output int nrd, output int nwr, output int nlow, output logic abort);
      int guard = 0;
      lat = -1; rdata = 32'hDEADDEAD; nrd = 0; nwr = 0; nlow = 0; abort = 1'bx;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_byte = byt;
      bus.req_addr = addr; bus.req_wdata = wdata;
      while (!bus.req_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = 32'hFFFF_FFFF;
      bus.req_wdata = 32'h0BAD_0BAD;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (!bus.req_ready) nlow++;
         if (bus.rsp_valid) begin
            lat = c; rdata = bus.rsp_rdata; abort = abort_sig;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks += 7;
      if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
      if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
      if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
      if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
      if (abort_sig !== 1'b0) begin failures++; $display("FAIL reset_abort got %b exp 0", abort_sig); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word();
      int lat, nrd, nwr, nlow; logic [31:0] rd; logic ab;
      do_req(STR, 1'b0, 32'h4, 32'hFFFF1100, lat, rd, nrd, nwr, nlow, ab);
      checks += 4;
      if (lat !== 2) begin failures++; $display("FAIL str_latency got %0d exp 2", lat); end
      if (nwr !== 1) begin failures++; $display("FAIL str_write_pulses got %0d exp 1", nwr); end
      if (nrd !== 0) begin failures++; $display("FAIL str_read_pulses got %0d exp 0", nrd); end
      if (rd !== 32'h0) begin failures++; $display("FAIL str_rdata got %h exp 0", rd); end
      do_req(LDR, 1'b0, 32'h4, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 4;
      if (lat !== 2) begin failures++; $display("FAIL ldr_latency got %0d exp 2", lat); end
      if (nrd !== 1) begin failures++; $display("FAIL ldr_read_pulses got %0d exp 1", nrd); end
      if (nwr !== 0) begin failures++; $display("FAIL ldr_write_pulses got %0d exp 0", nwr); end
      if (rd !== 32'hFFFF1100) begin failures++; $display("FAIL ldr_rdata got %h exp ffff1100", rd); end
      @(negedge clk);
      checks += 2;
      if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_one_cycle got %b exp 0", bus.rsp_valid); end
      if (bus.rsp_rdata !== 32'hFFFF1100) begin failures++; $display("FAIL rdata_hold got %h exp ffff1100", bus.rsp_rdata); end
   endtask

   task automatic test_byte();
      int lat, nrd, nwr, nlow; logic [31:0] rd; logic ab;
      do_req(STR, 1'b1, 32'h5, 32'h123456AB, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (lat !== 2) begin failures++; $display("FAIL strb_latency got %0d exp 2", lat); end
      do_req(LDR, 1'b0, 32'h4, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'hFFFFAB00) begin failures++; $display("FAIL strb_merge got %h exp ffffab00", rd); end
      do_req(LDR, 1'b1, 32'h5, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'h000000AB) begin failures++; $display("FAIL ldrb_lane1 got %h exp 000000ab", rd); end
      do_req(LDR, 1'b1, 32'h7, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'h000000FF) begin failures++; $display("FAIL ldrb_lane3 got %h exp 000000ff", rd); end
   endtask

   task automatic test_swap();
      int lat, nrd, nwr, nlow; logic [31:0] rd; logic ab;
      do_req(STR, 1'b0, 32'h4, 32'hFFFF1100, lat, rd, nrd, nwr, nlow, ab);
      do_req(SWP, 1'b0, 32'h4, 32'h00001212, lat, rd, nrd, nwr, nlow, ab);
      checks += 5;
      if (lat !== 3) begin failures++; $display("FAIL swp_latency got %0d exp 3", lat); end
      if (rd !== 32'hFFFF1100) begin failures++; $display("FAIL swp_old_data got %h exp ffff1100", rd); end
      if (nlow !== 3) begin failures++; $display("FAIL swp_ready_low got %0d exp 3", nlow); end
      if (nrd !== 1) begin failures++; $display("FAIL swp_read_pulses got %0d exp 1", nrd); end
      if (nwr !== 1) begin failures++; $display("FAIL swp_write_pulses got %0d exp 1", nwr); end
      do_req(LDR, 1'b0, 32'h4, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'h00001212) begin failures++; $display("FAIL swp_new_data got %h exp 00001212", rd); end
      // Byte swap on lane 0 of word 0x4 returns the old byte only.
      do_req(SWP, 1'b1, 32'h4, 32'h000000EE, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'h00000012) begin failures++; $display("FAIL swpb_old got %h exp 00000012", rd); end
      do_req(LDR, 1'b0, 32'h4, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'h000012EE) begin failures++; $display("FAIL swpb_new got %h exp 000012ee", rd); end
   endtask

   task automatic test_reserved();
      int lat, nrd, nwr, nlow; logic [31:0] rd; logic ab;
      do_req(RSV, 1'b0, 32'h4, 32'hFFFFFFFF, lat, rd, nrd, nwr, nlow, ab);
      checks += 3;
      if (lat !== 1) begin failures++; $display("FAIL rsv_latency got %0d exp 1", lat); end
      if (rd !== 32'h0) begin failures++; $display("FAIL rsv_rdata got %h exp 0", rd); end
      if (nrd + nwr !== 0) begin failures++; $display("FAIL rsv_strobes got %0d exp 0", nrd + nwr); end
   endtask

   task automatic test_misaligned();
      int lat, nrd, nwr, nlow; logic [31:0] rd; logic ab;
      do_req(LDR, 1'b0, 32'h6, 32'h0, lat, rd, nrd, nwr, nlow, ab);
`ifdef MEM_ALIGN_CHECK_EN
      checks += 4;
      if (lat !== 1) begin failures++; $display("FAIL abort_latency got %0d exp 1", lat); end
      if (ab !== 1'b1) begin failures++; $display("FAIL abort_flag got %b exp 1", ab); end
      if (nrd !== 0) begin failures++; $display("FAIL abort_no_read got %0d exp 0", nrd); end
      if (rd !== 32'h0) begin failures++; $display("FAIL abort_rdata got %h exp 0", rd); end
      do_req(STR, 1'b1, 32'h6, 32'h000000AB, lat, rd, nrd, nwr, nlow, ab);
      checks += 2;
      if (ab !== 1'b0) begin failures++; $display("FAIL strb_no_abort got %b exp 0", ab); end
      if (lat !== 2) begin failures++; $display("FAIL strb6_latency got %0d exp 2", lat); end
      do_req(LDR, 1'b0, 32'h4, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 2;
      if (ab !== 1'b0) begin failures++; $display("FAIL ldr_no_abort got %b exp 0", ab); end
      if (rd !== 32'h00AB12EE) begin failures++; $display("FAIL strb6_merge got %h exp 00ab12ee", rd); end
`else
      checks += 2;
      if (lat !== 2) begin failures++; $display("FAIL misalign_latency got %0d exp 2", lat); end
      if (rd !== 32'h000012EE) begin failures++; $display("FAIL misalign_ldr got %h exp 000012ee", rd); end
      do_req(STR, 1'b0, 32'h7, 32'h55667788, lat, rd, nrd, nwr, nlow, ab);
      do_req(LDR, 1'b0, 32'h4, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'h55667788) begin failures++; $display("FAIL misalign_str got %h exp 55667788", rd); end
`endif
   endtask

   task automatic test_wrap();
      int lat, nrd, nwr, nlow; logic [31:0] rd; logic ab;
      do_req(STR, 1'b0, 32'h8000_0404, 32'hCAFEF00D, lat, rd, nrd, nwr, nlow, ab);
      do_req(LDR, 1'b0, 32'h4, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL addr_wrap got %h exp cafef00d", rd); end
   endtask

   task automatic test_back_to_back();
      int n_acc = 0;
      int n_rsp = 0;
      int pos [3] = '{-1, -1, -1};
      bus.req_valid = 1'b1; bus.req_op = LDR; bus.req_byte = 1'b0;
      bus.req_addr = 32'h4; bus.req_wdata = 32'h0;
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         if (bus.req_ready) begin
            if (n_acc < 3) pos[n_acc] = i;
            n_acc++;
         end
         if (bus.rsp_valid) n_rsp++;
         @(negedge clk);
         if (i == 8) bus.req_valid = 1'b0;
      end
      checks += 5;
      if (n_acc !== 3) begin failures++; $display("FAIL b2b_accepts got %0d exp 3", n_acc); end
      if (n_rsp !== 3) begin failures++; $display("FAIL b2b_responses got %0d exp 3", n_rsp); end
      if (pos[1] - pos[0] !== 3) begin failures++; $display("FAIL b2b_gap1 got %0d exp 3", pos[1] - pos[0]); end
      if (pos[2] - pos[1] !== 3) begin failures++; $display("FAIL b2b_gap2 got %0d exp 3", pos[2] - pos[1]); end
      if (bus.rsp_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_rdata got %h exp cafef00d", bus.rsp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, nrd, nwr, nlow; logic [31:0] rd; logic ab;
      int seen = 0;
      do_req(STR, 1'b0, 32'h8, 32'h11111111, lat, rd, nrd, nwr, nlow, ab);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = SWP; bus.req_byte = 1'b0;
      bus.req_addr = 32'h8; bus.req_wdata = 32'h22222222;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      checks += 1;
      if (mem_read !== 1'b1) begin failures++; $display("FAIL mid_in_rd got %b exp 1", mem_read); end
      #1 rst_n = 1'b0;
      #1;
      checks += 4;
      if (mem_read !== 1'b0) begin failures++; $display("FAIL mid_mem_read got %b exp 0", mem_read); end
      if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got %b exp 0", busy); end
      if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got %b exp 1", bus.req_ready); end
      if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata got %h exp 0", bus.rsp_rdata); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.rsp_valid || mem_write) seen++;
      end
      checks += 1;
      if (seen !== 0) begin failures++; $display("FAIL mid_no_rsp got %0d exp 0", seen); end
      do_req(LDR, 1'b0, 32'h8, 32'h0, lat, rd, nrd, nwr, nlow, ab);
      checks += 1;
      if (rd !== 32'h11111111) begin failures++; $display("FAIL mid_array_kept got %h exp 11111111", rd); end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_byte = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0;
      test_reset();
      test_word();
      test_byte();
      test_swap();
      test_reserved();
      test_misaligned();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data-memory controller for the ARM pipelined core's MEM stage. It replaces the separate combinational data memory and swap-control FSM pair with one block that owns the array and sequences every access. Supported operations are LDR/STR/SWP in word and byte (LDRB/STRB/SWPB) forms, issued through a valid/ready request and a one-cycle response pulse. SWP is atomic: the read and the write occur back-to-back, and no other request is accepted in between.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, at least 16
ADDR_W, 32, byte-address width
DEPTH, 256, number of DATA_W words in the array; power of 2
LANE_W, $clog2(DATA_W/8), derived; number of byte-lane address bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request (IDLE only)
req_op  in  2  00 LDR, 01 STR, 10 SWP, 11 reserved
req_byte  in  1  1 = byte access on lane req_addr[LANE_W-1:0]
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store/swap data; byte ops use bits [7:0]
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  load/swap old data; byte results zero-extended
mem_read  out  1  array read strobe (high in RD)
mem_write  out  1  array write strobe (high in WR)
busy  out  1  not IDLE

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, mem_read=0, mem_write=0, busy=0, req_ready=1.
  - Latched request registers cleared. Array contents are not reset.
- Accept on the clk edge where req_valid && req_ready. The controller latches op, byte, addr and wdata; later changes on the req_* inputs are ignored.
- Word index = addr[LANE_W+$clog2(DEPTH)-1 : LANE_W]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- States: IDLE, RD, WR, RSP.
  - IDLE: req_ready=1. On accept: LDR/SWP -> RD; STR -> WR; op 11 -> RSP (no array access, rsp_rdata=0).
  - RD: mem_read=1. Array word registered into a read latch. LDR -> RSP; SWP -> WR.
  - WR: mem_write=1.
    - Word op: all bits written.
    - Byte op: only the selected lane is written; the other lanes keep their value.
    - Next state -> RSP.
  - RSP: rsp_valid=1 for exactly one cycle; next state -> IDLE.
    - rsp_rdata: read-latch word (LDR), or selected byte zero-extended (LDRB).
    - SWP returns the pre-write value. STR returns 0.
- Latency from accept edge to rsp_valid high: LDR 2 cycles, STR 2 cycles, SWP 3 cycles, op 11 1 cycle.
- Throughput: next accept is possible in the cycle after RSP (IDLE). There is no response backpressure.
- rsp_rdata holds its value until the next RSP or reset.
- Atomicity: req_ready=0 from RD through RSP, so no request can interleave between the SWP read and write.
- Reset mid-operation: if rst_n falls before the WR edge, no array write occurs. The FSM returns to IDLE and no response is issued.
- Misaligned word access (addr[LANE_W-1:0]!=0, req_byte=0): the low bits are ignored and the access is treated as word-aligned (unless the optional feature below is enabled).

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - Adds output rsp_abort (1 bit, reset 0), valid with rsp_valid.
  - A misaligned word request goes IDLE -> RSP with rsp_abort=1 and rsp_rdata=0. There is no read or write strobe and the array is untouched.
  - Aligned and byte requests give rsp_abort=0.
- Undefined: the port is absent and misaligned addresses are silently aligned.

Test Plan:
- STR word 0xFFFF1100 to addr 0x4, then LDR 0x4 -> rsp_rdata=0xFFFF1100; rsp_valid exactly 2 cycles after each accept; mem_write pulses once, mem_read pulses once.
- STRB 0xAB to addr 0x5 over word 0xFFFF1100 -> LDR 0x4 returns 0xFFFFAB00; LDRB 0x5 returns 0x000000AB.
- Word 0x4 = 0xFFFF1100; SWP addr 0x4 wdata 0x00001212 -> rsp_rdata=0xFFFF1100 3 cycles after accept; req_ready low for RD/WR/RSP; following LDR 0x4 returns 0x00001212.
- Back-to-back: req_valid held with LDR requests -> accepts every 3 cycles; a request presented while busy is not accepted until IDLE.
- Word 0x8 = 0x11111111; rst_n pulsed low during RD of SWP to 0x8 (wdata 0x22222222) -> all outputs reset immediately; no rsp_valid; subsequent LDR 0x8 returns 0x11111111.
- With MEM_ALIGN_CHECK_EN: LDR addr 0x6 -> rsp_valid with rsp_abort=1 one cycle after accept, mem_read never high; STRB to addr 0x6 completes with rsp_abort=0.
